// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// The state encoding is fixed so that debug probes read IDLE=0 and BURST=1.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DW        = 16;
  localparam int DEF_BURST_LEN = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority picker: the search starts one past last_owner and the
// first set req bit wins, wrapping from N_REQ-1 back to 0.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_owner,
  output logic             any,
  output logic [IW-1:0]    winner
);

  int idx;

  // Walk from the farthest candidate to the nearest so the nearest set bit is
  // the last assignment and therefore the winner.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last_owner) + k) % N_REQ;
      if (req[IW'(idx)]) begin
        any    = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates N_REQ producers onto the write port of an external FIFO, granting
// round-robin bursts of up to BURST_LEN words; writes themselves are combinational.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DW        = DEF_DW,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    gnt,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [DW-1:0]       fifo_din,
  output state_e              dbg_state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshake: a producer presents req[i] with stable data and holds both until
  // ack[i]; ack[i] is high in exactly the cycle its word is written to the FIFO.

  state_e        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last_owner;
  logic [3:0]    burst_cnt;

  logic [DW-1:0] slot [N_REQ];
  logic [IW-1:0] pick_ptr;
  logic          pick_any;
  logic [IW-1:0] pick_winner;
  logic          wr_en;
  logic          burst_end;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    assign slot[g] = req_data[g*DW +: DW];
  end

  // At a burst end the pointer is already considered updated to the owner,
  // so the same-cycle re-arbitration searches from owner+1.
  assign pick_ptr = (state == BURST) ? owner : last_owner;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req        (req),
    .last_owner (pick_ptr),
    .any        (pick_any),
    .winner     (pick_winner)
  );

  assign wr_en     = (state == BURST) && req[owner] && !fifo_full;
  assign burst_end = (state == BURST) &&
                     ((wr_en && (burst_cnt == 4'(BURST_LEN - 1))) || !req[owner]);

  always_comb begin
    gnt = '0;
    if (state == BURST) gnt[owner] = 1'b1;
  end

  assign ack        = wr_en ? gnt : '0;
  assign fifo_wr_en = wr_en;
  assign fifo_din   = (state == BURST) ? slot[owner] : '0;
  assign dbg_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IW'(N_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= BURST;
            owner     <= pick_winner;
            burst_cnt <= '0;
          end
        end
        BURST: begin
          if (burst_end) begin
            last_owner <= owner;
            burst_cnt  <= '0;
            if (pick_any) begin
              owner <= pick_winner;
            end else begin
              state <= IDLE;
            end
          end else if (wr_en) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
